// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and a
// synchronous instruction memory (slave). Read data returns the cycle after the strobe.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
) ();
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_rd_en;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_addr, output imem_rd_en, input imem_rdata);
  modport slave  (input imem_addr, input imem_rd_en, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues synchronous imem reads, and holds the
// FE/DE register with a one-entry skid buffer that catches the in-flight word during a stall.
module fetch_stage #(
  parameter int          PC_WIDTH    = 16,
  parameter int          INSTR_WIDTH = 32,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_stage_if.master          imem,
  input  logic                   DE_stall,
  input  logic                   EX_branch_taken,
  input  logic [PC_WIDTH-1:0]    EX_branch_target,
  input  logic                   halt,
  output logic [INSTR_WIDTH-1:0] FE_DE_instr,
  output logic [PC_WIDTH-1:0]    FE_DE_PC,
  output logic                   FE_DE_valid,
  output logic                   FE_halted
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_infl_vld_p0;
  logic [PC_WIDTH-1:0]    r_infl_pc_p0;
  logic                   r_skid_vld_p1;
  logic [INSTR_WIDTH-1:0] r_skid_instr_p1;
  logic [PC_WIDTH-1:0]    r_skid_pc_p1;
  logic                   r_fe_vld_p1;
  logic [INSTR_WIDTH-1:0] r_fe_instr_p1;
  logic [PC_WIDTH-1:0]    r_fe_pc_p1;
  logic                   r_halted;

  logic w_run;
  logic w_issue;
  logic w_capture;

  // Halt and branch outrank stall; a stall only captures when a word is actually returning.
  assign w_run     = (r_state == S_RUN);
  assign w_issue   = w_run & ~rst & ~DE_stall & ~halt & ~EX_branch_taken;
  assign w_capture = w_run & ~rst & ~halt & ~EX_branch_taken & DE_stall & r_infl_vld_p0;

  assign imem.imem_addr  = r_pc;
  assign imem.imem_rd_en = w_issue;

  assign FE_DE_instr = r_fe_instr_p1;
  assign FE_DE_PC    = r_fe_pc_p1;
  assign FE_DE_valid = r_fe_vld_p1;
  assign FE_halted   = r_halted;

  // Issue stage (p0) and FE/DE stage (p1) control, plus the RUN/HALT FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_pc          <= PC_WIDTH'(RESET_PC);
      r_infl_vld_p0 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_fe_vld_p1   <= 1'b0;
      r_fe_instr_p1 <= '0;
      r_fe_pc_p1    <= '0;
      r_halted      <= 1'b0;
    end else if (r_state == S_HALT) begin
      r_infl_vld_p0 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_fe_vld_p1   <= 1'b0;
    end else if (halt) begin
      r_state       <= S_HALT;
      r_halted      <= 1'b1;
      r_infl_vld_p0 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_fe_vld_p1   <= 1'b0;
    end else if (EX_branch_taken) begin
      r_pc          <= EX_branch_target;
      r_infl_vld_p0 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_fe_vld_p1   <= 1'b0;
    end else if (DE_stall) begin
      if (r_infl_vld_p0) r_skid_vld_p1 <= 1'b1;
      r_infl_vld_p0 <= 1'b0;
    end else begin
      if (r_skid_vld_p1) begin
        r_fe_vld_p1   <= 1'b1;
        r_fe_instr_p1 <= r_skid_instr_p1;
        r_fe_pc_p1    <= r_skid_pc_p1;
        r_skid_vld_p1 <= 1'b0;
      end else begin
        r_fe_vld_p1   <= r_infl_vld_p0;
        r_fe_instr_p1 <= imem.imem_rdata;
        r_fe_pc_p1    <= r_infl_pc_p0;
      end
      r_infl_vld_p0 <= 1'b1;
      r_pc          <= r_pc + 1'b1;
    end
  end

  // Payload registers carry no reset; their valid bits above qualify them
  always_ff @(posedge clk) begin
    if (w_issue) r_infl_pc_p0 <= r_pc;
    if (w_capture) begin
      r_skid_instr_p1 <= imem.imem_rdata;
      r_skid_pc_p1    <= r_infl_pc_p0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, branch redirects, halt,
// PC wrap on a 4-bit instance, and reset during a stall.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        DE_stall;
  logic        EX_branch_taken;
  logic [15:0] EX_branch_target;
  logic        halt;
  logic [31:0] fe_instr_a;
  logic [15:0] fe_pc_a;
  logic        fe_vld_a;
  logic        halted_a;

  logic        zero_b;
  logic [3:0]  zero_tgt_b;
  logic [31:0] fe_instr_b;
  logic [3:0]  fe_pc_b;
  logic        fe_vld_b;
  logic        halted_b;

  int n_checks;
  int n_errors;

  fetch_stage_if #(.PC_WIDTH(16), .INSTR_WIDTH(32)) ifa ();
  fetch_stage_if #(.PC_WIDTH(4),  .INSTR_WIDTH(32)) ifb ();

  fetch_stage #(.PC_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(0)) dut_a (
    .clk(clk), .rst(rst), .imem(ifa.master),
    .DE_stall(DE_stall), .EX_branch_taken(EX_branch_taken),
    .EX_branch_target(EX_branch_target), .halt(halt),
    .FE_DE_instr(fe_instr_a), .FE_DE_PC(fe_pc_a),
    .FE_DE_valid(fe_vld_a), .FE_halted(halted_a)
  );

  fetch_stage #(.PC_WIDTH(4), .INSTR_WIDTH(32), .RESET_PC(14)) dut_b (
    .clk(clk), .rst(rst), .imem(ifb.master),
    .DE_stall(zero_b), .EX_branch_taken(zero_b),
    .EX_branch_target(zero_tgt_b), .halt(zero_b),
    .FE_DE_instr(fe_instr_b), .FE_DE_PC(fe_pc_b),
    .FE_DE_valid(fe_vld_b), .FE_halted(halted_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at address a is 0xA000_0000 + a
  always @(posedge clk) begin
    if (ifa.imem_rd_en) ifa.imem_rdata <= 32'hA000_0000 + 32'(ifa.imem_addr);
    if (ifb.imem_rd_en) ifb.imem_rdata <= 32'hA000_0000 + 32'(ifb.imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fe(input string tag, input logic v, input int pc);
    check({tag, " vld"}, 64'(fe_vld_a), 64'(v));
    if (v) begin
      check({tag, " pc"}, 64'(fe_pc_a), 64'(pc[15:0]));
      check({tag, " instr"}, 64'(fe_instr_a), 64'(32'hA000_0000 + 32'(pc[15:0])));
    end
  endtask

  task automatic expect_halted();
    check("halted flag", 64'(halted_a), 64'd1);
    check("halted vld", 64'(fe_vld_a), 64'd0);
    check("halted rd_en", 64'(ifa.imem_rd_en), 64'd0);
  endtask

  task automatic expect_reset_state();
    check("rst vld", 64'(fe_vld_a), 64'd0);
    check("rst pc", 64'(fe_pc_a), 64'd0);
    check("rst instr", 64'(fe_instr_a), 64'd0);
    check("rst halted", 64'(halted_a), 64'd0);
    check("rst addr", 64'(ifa.imem_addr), 64'd0);
    check("rst rd_en", 64'(ifa.imem_rd_en), 64'd0);
  endtask

  // Cycles 0..n-1 after reset release with no stall/branch/halt
  task automatic run_stream(input int n, input bit wrap);
    int wpc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("stream rd_en", 64'(ifa.imem_rd_en), 64'd1);
      check("stream addr", 64'(ifa.imem_addr), 64'(k));
      expect_fe("stream", k >= 2, k - 2);
      if (wrap) begin
        check("wrap addr", 64'(ifb.imem_addr), 64'((14 + k) % 16));
        check("wrap vld", 64'(fe_vld_b), 64'(k >= 2));
        if (k >= 2) begin
          wpc = (14 + k - 2) % 16;
          check("wrap pc", 64'(fe_pc_b), 64'(wpc));
          check("wrap instr", 64'(fe_instr_b), 64'(32'hA000_0000 + 32'(wpc)));
        end
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    DE_stall = 1'b0;
    EX_branch_taken = 1'b0;
    EX_branch_target = 16'h0040;
    halt = 1'b0;
    zero_b = 1'b0;
    zero_tgt_b = 4'd0;

    @(negedge clk);
    check("rst rd_en pre", 64'(ifa.imem_rd_en), 64'd0);
    tick();
    @(negedge clk);
    expect_reset_state();
    check("wrap rst addr", 64'(ifb.imem_addr), 64'd14);
    tick();
    rst = 1'b0;

    // Stream and wrap, then stall with PC 5 on FE/DE and PC 6 in flight
    run_stream(7, 1'b1);
    DE_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_fe("stall hold", 1'b1, 5);
      check("stall rd_en", 64'(ifa.imem_rd_en), 64'd0);
      tick();
    end
    DE_stall = 1'b0;
    @(negedge clk);
    expect_fe("release", 1'b1, 5);
    check("release addr", 64'(ifa.imem_addr), 64'd7);
    check("release rd_en", 64'(ifa.imem_rd_en), 64'd1);
    tick();
    for (int p = 6; p <= 8; p++) begin
      @(negedge clk);
      expect_fe("after skid", 1'b1, p);
      tick();
    end

    // Branch in a normal cycle
    EX_branch_taken = 1'b1;
    @(negedge clk);
    expect_fe("br cycle", 1'b1, 9);
    check("br rd_en", 64'(ifa.imem_rd_en), 64'd0);
    tick();
    EX_branch_taken = 1'b0;
    @(negedge clk);
    expect_fe("br +1", 1'b0, 0);
    check("br target addr", 64'(ifa.imem_addr), 64'h40);
    check("br target rd_en", 64'(ifa.imem_rd_en), 64'd1);
    tick();
    @(negedge clk);
    expect_fe("br +2", 1'b0, 0);
    tick();
    for (int p = 'h40; p <= 'h42; p++) begin
      @(negedge clk);
      expect_fe("br stream", 1'b1, p);
      tick();
    end

    // Branch during a stall that already filled the skid with 0x44
    DE_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      expect_fe("stall2 hold", 1'b1, 'h43);
      tick();
    end
    EX_branch_taken = 1'b1;
    @(negedge clk);
    expect_fe("stall br cycle", 1'b1, 'h43);
    check("stall br rd_en", 64'(ifa.imem_rd_en), 64'd0);
    tick();
    EX_branch_taken = 1'b0;
    DE_stall = 1'b0;
    @(negedge clk);
    expect_fe("stall br +1", 1'b0, 0);
    check("stall br addr", 64'(ifa.imem_addr), 64'h40);
    tick();
    @(negedge clk);
    expect_fe("stall br +2", 1'b0, 0);
    tick();
    @(negedge clk);
    expect_fe("stall br +3", 1'b1, 'h40);
    tick();
    @(negedge clk);
    expect_fe("stall br +4", 1'b1, 'h41);
    tick();

    // Reset while stalled with the skid holding 0x43
    DE_stall = 1'b1;
    @(negedge clk);
    expect_fe("pre rst stall", 1'b1, 'h42);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst rd_en", 64'(ifa.imem_rd_en), 64'd0);
    tick();
    DE_stall = 1'b0;
    @(negedge clk);
    expect_reset_state();
    tick();
    rst = 1'b0;
    run_stream(11, 1'b0);

    // Halt at PC 9, then branch and stall must be ignored
    halt = 1'b1;
    @(negedge clk);
    expect_fe("halt cycle", 1'b1, 9);
    check("halt cycle rd_en", 64'(ifa.imem_rd_en), 64'd0);
    tick();
    halt = 1'b0;
    EX_branch_taken = 1'b1;
    @(negedge clk);
    expect_halted();
    tick();
    EX_branch_taken = 1'b0;
    DE_stall = 1'b1;
    @(negedge clk);
    expect_halted();
    tick();
    DE_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_halted();
      tick();
    end

    rst = 1'b1;
    tick();
    @(negedge clk);
    expect_reset_state();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post halt rd_en", 64'(ifa.imem_rd_en), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
